version_store_writer: RTL and testbench

Write-side companion to the version priority router: accepts versioned data words over a valid/ready handshake, places each into one of `VERSION_NUM` tagged storage slots, and drives the flattened version-tag and data buses the router reads. Each write scans every slot, then commits as a same-version update, an insert into a free slot, an eviction of the oldest version, or a reject. It sits between the producer of versioned results and one or more routers sharing its storage.

---
 rtl/version_store_writer_pkg.sv | 23 ++
 rtl/version_store_writer_slot_scan.sv | 94 +++++++++
 rtl/version_store_writer.sv | 192 +++++++++++++++++++
 tb/tb_version_store_writer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/version_store_writer_pkg.sv
// Shared encodings for the versioned storage writer: status codes, FSM states
// and default geometry used by the top and its scan sub-module.
package version_store_writer_pkg;

  localparam int DEF_DATA_WIDTH    = 32;
  localparam int DEF_VERSION_WIDTH = 4;
  localparam int DEF_VERSION_NUM   = 4;

  localparam int SLOT_W = $clog2(DEF_VERSION_NUM);
  localparam logic [DEF_VERSION_WIDTH-1:0] EMPTY_TAG = '1;

  localparam logic [1:0] ST_UPDATE = 2'd0;
  localparam logic [1:0] ST_INSERT = 2'd1;
  localparam logic [1:0] ST_EVICT  = 2'd2;
  localparam logic [1:0] ST_REJECT = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCAN   = 2'd1,
    S_COMMIT = 2'd2
  } wr_state_e;

endpackage

// File: rtl/version_store_writer_slot_scan.sv
// Scan trackers: walks one slot per step and remembers the first matching tag,
// the lowest free slot and the valid slot holding the smallest tag.
module version_slot_scan #(
  parameter int VERSION_WIDTH = 4,
  parameter int SW            = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     step,
  input  logic [SW-1:0]            idx,
  input  logic                     cur_valid,
  input  logic [VERSION_WIDTH-1:0] cur_tag,
  input  logic [VERSION_WIDTH-1:0] req_tag,
  output logic                     match_found,
  output logic [SW-1:0]            match_idx,
  output logic                     free_found,
  output logic [SW-1:0]            free_idx,
  output logic                     min_found,
  output logic [SW-1:0]            min_idx,
  output logic [VERSION_WIDTH-1:0] min_tag
);

  logic                     match_found_q, match_found_d;
  logic [SW-1:0]            match_idx_q, match_idx_d;
  logic                     free_found_q, free_found_d;
  logic [SW-1:0]            free_idx_q, free_idx_d;
  logic                     min_found_q, min_found_d;
  logic [SW-1:0]            min_idx_q, min_idx_d;
  logic [VERSION_WIDTH-1:0] min_tag_q, min_tag_d;

  always_comb begin
    match_found_d = match_found_q;
    match_idx_d   = match_idx_q;
    free_found_d  = free_found_q;
    free_idx_d    = free_idx_q;
    min_found_d   = min_found_q;
    min_idx_d     = min_idx_q;
    min_tag_d     = min_tag_q;
    if (start) begin
      match_found_d = 1'b0;
      match_idx_d   = '0;
      free_found_d  = 1'b0;
      free_idx_d    = '0;
      min_found_d   = 1'b0;
      min_idx_d     = '0;
      min_tag_d     = '0;
    end else if (step) begin
      if (cur_valid && (cur_tag == req_tag) && !match_found_q) begin
        match_found_d = 1'b1;
        match_idx_d   = idx;
      end
      if (!cur_valid && !free_found_q) begin
        free_found_d = 1'b1;
        free_idx_d   = idx;
      end
      // Tags are unique among valid slots, so strict less-than suffices.
      if (cur_valid && (!min_found_q || (cur_tag < min_tag_q))) begin
        min_found_d = 1'b1;
        min_idx_d   = idx;
        min_tag_d   = cur_tag;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_found_q <= 1'b0;
      match_idx_q   <= '0;
      free_found_q  <= 1'b0;
      free_idx_q    <= '0;
      min_found_q   <= 1'b0;
      min_idx_q     <= '0;
      min_tag_q     <= '0;
    end else begin
      match_found_q <= match_found_d;
      match_idx_q   <= match_idx_d;
      free_found_q  <= free_found_d;
      free_idx_q    <= free_idx_d;
      min_found_q   <= min_found_d;
      min_idx_q     <= min_idx_d;
      min_tag_q     <= min_tag_d;
    end
  end

  assign match_found = match_found_q;
  assign match_idx   = match_idx_q;
  assign free_found  = free_found_q;
  assign free_idx    = free_idx_q;
  assign min_found   = min_found_q;
  assign min_idx     = min_idx_q;
  assign min_tag     = min_tag_q;

endmodule

// File: rtl/version_store_writer.sv
// Versioned slot storage with a scan/commit write FSM; drives flattened tag and
// data buses where empty slots read as all-ones tag and zero data.
module version_store_writer
  import version_store_writer_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int VERSION_WIDTH = DEF_VERSION_WIDTH,
  parameter int VERSION_NUM   = DEF_VERSION_NUM
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 clear,
  input  logic                                 wrValid,
  output logic                                 wrReady,
  input  logic [VERSION_WIDTH-1:0]             wrVersion,
  input  logic [DATA_WIDTH-1:0]                wrData,
  output logic                                 wrDone,
  output logic [1:0]                           wrStatus,
  output logic [$clog2(VERSION_NUM)-1:0]       wrSlot,
  output logic [VERSION_NUM-1:0]               slotValid,
  output logic [VERSION_WIDTH*VERSION_NUM-1:0] versions,
  output logic [DATA_WIDTH*VERSION_NUM-1:0]    dataInputs,
  output logic [1:0]                           dbg_state
);

  localparam int SW = $clog2(VERSION_NUM);
  localparam logic [VERSION_WIDTH-1:0] TAG_ONES = '1;

  // Handshake: a request is taken on any rising edge where wrValid & wrReady;
  // wrReady is a registered IDLE flag and never looks at wrValid.
  wr_state_e                state_q, state_d;
  logic [SW-1:0]            idx_q, idx_d;
  logic [VERSION_WIDTH-1:0] req_ver_q, req_ver_d;
  logic [DATA_WIDTH-1:0]    req_data_q, req_data_d;
  logic                     ready_q, ready_d;
  logic                     done_q, done_d;
  logic                     scan_start, scan_step;

  logic [VERSION_NUM-1:0]   slot_valid_q, slot_valid_d;
  logic [VERSION_WIDTH-1:0] slot_tag_q  [VERSION_NUM];
  logic [VERSION_WIDTH-1:0] slot_tag_d  [VERSION_NUM];
  logic [DATA_WIDTH-1:0]    slot_data_q [VERSION_NUM];
  logic [DATA_WIDTH-1:0]    slot_data_d [VERSION_NUM];

  logic                     match_found, free_found, min_found;
  logic [SW-1:0]            match_idx, free_idx, min_idx;
  logic [VERSION_WIDTH-1:0] min_tag;
  logic [1:0]               dec_status;
  logic [SW-1:0]            dec_slot;

  version_slot_scan #(
    .VERSION_WIDTH (VERSION_WIDTH),
    .SW            (SW)
  ) u_scan (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (scan_start),
    .step        (scan_step),
    .idx         (idx_q),
    .cur_valid   (slot_valid_q[idx_q]),
    .cur_tag     (slot_tag_q[idx_q]),
    .req_tag     (req_ver_q),
    .match_found (match_found),
    .match_idx   (match_idx),
    .free_found  (free_found),
    .free_idx    (free_idx),
    .min_found   (min_found),
    .min_idx     (min_idx),
    .min_tag     (min_tag)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    req_ver_d  = req_ver_q;
    req_data_d = req_data_q;
    ready_d    = ready_q;
    done_d     = 1'b0;
    scan_start = 1'b0;
    scan_step  = 1'b0;
    if (clear) begin
      state_d = S_IDLE;
      ready_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (wrValid) begin
            req_ver_d  = wrVersion;
            req_data_d = wrData;
            idx_d      = '0;
            scan_start = 1'b1;
            ready_d    = 1'b0;
            state_d    = S_SCAN;
          end
        end
        S_SCAN: begin
          scan_step = 1'b1;
          if (idx_q == SW'(VERSION_NUM - 1)) begin
            state_d = S_COMMIT;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + SW'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          ready_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      req_ver_q  <= '0;
      req_data_q <= '0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      req_ver_q  <= req_ver_d;
      req_data_q <= req_data_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
    end
  end

  // Commit decision uses the fully advanced trackers, valid throughout COMMIT.
  always_comb begin
    dec_status = ST_REJECT;
    dec_slot   = '0;
    if (req_ver_q == TAG_ONES) begin
      dec_status = ST_REJECT;
    end else if (match_found) begin
      dec_status = ST_UPDATE;
      dec_slot   = match_idx;
    end else if (free_found) begin
      dec_status = ST_INSERT;
      dec_slot   = free_idx;
    end else if (min_found && (req_ver_q > min_tag)) begin
      dec_status = ST_EVICT;
      dec_slot   = min_idx;
    end
  end

  always_comb begin
    slot_valid_d = slot_valid_q;
    slot_tag_d   = slot_tag_q;
    slot_data_d  = slot_data_q;
    if (clear) begin
      slot_valid_d = '0;
    end else if (state_q == S_COMMIT) begin
      case (dec_status)
        ST_UPDATE: slot_data_d[dec_slot] = req_data_q;
        ST_INSERT, ST_EVICT: begin
          slot_valid_d[dec_slot] = 1'b1;
          slot_tag_d[dec_slot]   = req_ver_q;
          slot_data_d[dec_slot]  = req_data_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_valid_q <= '0;
      slot_tag_q   <= '{default: '0};
      slot_data_q  <= '{default: '0};
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_tag_q   <= slot_tag_d;
      slot_data_q  <= slot_data_d;
    end
  end

  for (genvar i = 0; i < VERSION_NUM; i++) begin : g_flat
    assign versions[i*VERSION_WIDTH +: VERSION_WIDTH] = slot_valid_q[i] ? slot_tag_q[i] : TAG_ONES;
    assign dataInputs[i*DATA_WIDTH +: DATA_WIDTH]     = slot_valid_q[i] ? slot_data_q[i] : '0;
  end

  assign wrReady   = ready_q;
  assign wrDone    = done_q;
  assign wrStatus  = done_q ? dec_status : 2'd0;
  assign wrSlot    = done_q ? dec_slot : '0;
  assign slotValid = slot_valid_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_version_store_writer.sv
// Self-checking bench for version_store_writer: directed scenarios plus random
// writes compared against a slot-array reference model.
module tb_version_store_writer;
  import version_store_writer_pkg::*;

  localparam int DW = 32;
  localparam int VW = 4;
  localparam int VN = 4;
  localparam int SW = $clog2(VN);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clear = 1'b0;
  logic             wrValid = 1'b0;
  logic             wrReady;
  logic [VW-1:0]    wrVersion = '0;
  logic [DW-1:0]    wrData = '0;
  logic             wrDone;
  logic [1:0]       wrStatus;
  logic [SW-1:0]    wrSlot;
  logic [VN-1:0]    slotValid;
  logic [VW*VN-1:0] versions;
  logic [DW*VN-1:0] dataInputs;
  logic [1:0]       dbg_state;

  version_store_writer #(
    .DATA_WIDTH    (DW),
    .VERSION_WIDTH (VW),
    .VERSION_NUM   (VN)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .wrValid    (wrValid),
    .wrReady    (wrReady),
    .wrVersion  (wrVersion),
    .wrData     (wrData),
    .wrDone     (wrDone),
    .wrStatus   (wrStatus),
    .wrSlot     (wrSlot),
    .slotValid  (slotValid),
    .versions   (versions),
    .dataInputs (dataInputs),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model: plain arrays of slots
  bit            m_valid [VN];
  int            m_tag   [VN];
  logic [DW-1:0] m_data  [VN];

  task automatic model_clear();
    for (int i = 0; i < VN; i++) m_valid[i] = 1'b0;
  endtask

  task automatic model_write(input int v, input logic [DW-1:0] d, output int st, output int slot);
    int hit, fr, mn;
    hit = -1; fr = -1; mn = -1;
    st = 3; slot = 0;
    for (int i = 0; i < VN; i++) begin
      if (m_valid[i] && m_tag[i] == v && hit < 0) hit = i;
      if (!m_valid[i] && fr < 0) fr = i;
      if (m_valid[i] && (mn < 0 || m_tag[i] < m_tag[mn])) mn = i;
    end
    if (v == (1 << VW) - 1) begin
      st = 3;
    end else if (hit >= 0) begin
      st = 0; slot = hit; m_data[hit] = d;
    end else if (fr >= 0) begin
      st = 1; slot = fr; m_valid[fr] = 1'b1; m_tag[fr] = v; m_data[fr] = d;
    end else if (v > m_tag[mn]) begin
      st = 2; slot = mn; m_tag[mn] = v; m_data[mn] = d;
    end
  endtask

  task automatic check_storage(input string tag);
    logic [VN-1:0] ev;
    for (int i = 0; i < VN; i++) begin
      ev[i] = m_valid[i];
      check($sformatf("%s_tag%0d", tag, i), 64'(versions[i*VW +: VW]),
            m_valid[i] ? 64'(m_tag[i]) : 64'((1 << VW) - 1));
      check($sformatf("%s_data%0d", tag, i), 64'(dataInputs[i*DW +: DW]),
            m_valid[i] ? 64'(m_data[i]) : 64'd0);
    end
    check($sformatf("%s_slotvalid", tag), 64'(slotValid), 64'(ev));
  endtask

  // driver tasks; every task is entered and left at a falling edge
  task automatic do_write(input int v, input logic [DW-1:0] d);
    int st, slot, lat;
    bit seen;
    for (int k = 0; k < 20 && !wrReady; k++) @(negedge clk);
    check("ready_before_req", 64'(wrReady), 64'd1);
    wrValid = 1'b1; wrVersion = VW'(v); wrData = d;
    @(posedge clk);
    #1 wrValid = 1'b0;
    model_write(v, d, st, slot);
    lat = 0; seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      lat++;
      if (wrDone) begin seen = 1'b1; break; end
    end
    check("done_seen", 64'(seen), 64'd1);
    check("done_latency", 64'(lat), 64'(VN + 1));
    check($sformatf("status_v%0d", v), 64'(wrStatus), 64'(st));
    check($sformatf("slot_v%0d", v), 64'(wrSlot), 64'(slot));
    check("ready_in_commit", 64'(wrReady), 64'd0);
    @(negedge clk);
    check("done_one_cycle", 64'(wrDone), 64'd0);
    check("ready_after_commit", 64'(wrReady), 64'd1);
    check_storage($sformatf("after_v%0d", v));
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    model_clear();
    @(negedge clk);
    check("clear_slotvalid", 64'(slotValid), 64'd0);
    check("clear_ready", 64'(wrReady), 64'd1);
  endtask

  // scoreboard for the back-to-back phase: {status, slot}
  logic [SW+1:0] exp_q[$];
  int            hs_cyc[$];

  initial begin
    int list [7];
    int st, slot, issued, dones;
    bit seen;
    logic [SW+1:0] e;
    list = '{1, 4, 6, 10, 12, 13, 14};

    model_clear();
    for (int i = 0; i < VN; i++) begin m_tag[i] = 0; m_data[i] = '0; end
    repeat (3) @(negedge clk);
    check("reset_ready", 64'(wrReady), 64'd1);
    check("reset_done", 64'(wrDone), 64'd0);
    check("reset_status", 64'(wrStatus), 64'd0);
    check("reset_slot", 64'(wrSlot), 64'd0);
    check("reset_versions", 64'(versions), 64'hFFFF);
    check_storage("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // first insert then same-version update
    do_write(5, 32'hAAAA);
    check("first_insert_tag0", 64'(versions), 64'hFFF5);
    do_write(5, 32'hBBBB);
    check("update_data0", 64'(dataInputs[DW-1:0]), 64'hBBBB);

    // fill, evict oldest, reject older and all-ones tag
    do_clear();
    do_write(3, 32'h3333);
    do_write(7, 32'h7777);
    do_write(9, 32'h9999);
    do_write(11, 32'hBBBB_0011);
    do_write(8, 32'h8888);
    check("evict_slot0_tag", 64'(versions), 64'hB978);
    do_write(2, 32'h2222);
    do_write(15, 32'hFFFF);
    do_clear();
    do_write(15, 32'h1515);

    // clear while scanning drops the request
    wrValid = 1'b1; wrVersion = 4'd6; wrData = 32'h6666;
    @(posedge clk);
    #1 wrValid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    model_clear();
    @(negedge clk);
    check("scan_clear_slotvalid", 64'(slotValid), 64'd0);
    check("scan_clear_ready", 64'(wrReady), 64'd1);
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (wrDone) seen = 1'b1;
      @(negedge clk);
    end
    check("scan_clear_no_done", 64'(seen), 64'd0);
    do_write(4, 32'h4444);

    // async reset during COMMIT
    wrValid = 1'b1; wrVersion = 4'd9; wrData = 32'h9009;
    @(posedge clk);
    #1 wrValid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (wrDone) begin seen = 1'b1; break; end
    end
    check("rst_commit_done_seen", 64'(seen), 64'd1);
    rst_n = 1'b0;
    #1;
    model_clear();
    check("rst_ready", 64'(wrReady), 64'd1);
    check("rst_done", 64'(wrDone), 64'd0);
    check("rst_status", 64'(wrStatus), 64'd0);
    check("rst_slot", 64'(wrSlot), 64'd0);
    check_storage("rst_commit");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // back-to-back with wrValid held high
    issued = 0; dones = 0;
    wrValid = 1'b1; wrVersion = VW'(list[0]); wrData = 32'hC000_0000;
    for (int cyc = 0; cyc < 120 && (issued < 7 || exp_q.size() > 0); cyc++) begin
      bit hs;
      hs = 1'b0;
      if (wrDone) begin
        dones++;
        if (exp_q.size() == 0) check("b2b_spurious_done", 64'd1, 64'd0);
        else begin
          e = exp_q.pop_front();
          check("b2b_status_slot", 64'({wrStatus, wrSlot}), 64'(e));
        end
      end
      if (wrValid && wrReady) begin
        model_write(list[issued], wrData, st, slot);
        exp_q.push_back({st[1:0], slot[SW-1:0]});
        hs_cyc.push_back(cyc);
        issued++;
        hs = 1'b1;
      end
      @(posedge clk);
      #1;
      if (hs) begin
        if (issued < 7) begin
          wrVersion = VW'(list[issued]);
          wrData = 32'hC000_0000 + 32'(issued);
        end else wrValid = 1'b0;
      end
      @(negedge clk);
    end
    wrValid = 1'b0;
    check("b2b_issued", 64'(issued), 64'd7);
    check("b2b_dones", 64'(dones), 64'd7);
    check("b2b_queue_empty", 64'(exp_q.size()), 64'd0);
    for (int k = 1; k < hs_cyc.size(); k++)
      check($sformatf("b2b_spacing%0d", k), 64'(hs_cyc[k] - hs_cyc[k-1]), 64'(VN + 2));
    check_storage("b2b");

    // random writes with occasional clears
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) == 0) do_clear();
      do_write(int'($urandom_range(0, 15)), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
